// File: rtl/spi_txn_arbiter_pkg.sv
// Shared definitions for the SPI transaction arbiter.
//   - 3-bit state encodings and the state_t enum built on them
//   - requester index constants (SD card reader, MP3 decoder)
package spi_txn_arbiter_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_ISSUE   = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_SETUP   = ST_SETUP,
    S_ISSUE   = ST_ISSUE,
    S_WAIT    = ST_WAIT,
    S_HOLD    = ST_HOLD,
    S_RELEASE = ST_RELEASE
  } state_t;

  localparam int REQ_SD  = 0;
  localparam int REQ_MP3 = 1;

endpackage

// File: rtl/spi_txn_arbiter_if.sv
// Bus bundle between the two requesters, the byte engine and the arbiter.
//   master modport: requester/engine side (drives req, len, tx_byte, eng_rx, eng_done)
//   slave modport : arbiter side (drives grant, cs_n, tx_take, rx_*, txn_done, eng_go, eng_tx)
//
// Handshake semantics (all single-cycle pulses are sampled on the rising edge):
//   req[i] is a level; the arbiter answers with grant[i], which stays high up to
//   and including the txn_done[i] pulse. tx_take[i] pulses in the same cycle as
//   eng_go and means tx_byte[i] was consumed; the requester then presents the
//   next byte. rx_valid[i] pulses for exactly one cycle with rx_byte. eng_go is a
//   one-cycle start with eng_tx valid; eng_done is a one-cycle completion with
//   eng_rx valid and is only honoured while a byte is outstanding.
interface spi_txn_arbiter_if #(parameter int LEN_W = 9);
  logic [1:0]         req;
  logic [2*LEN_W-1:0] len;
  logic [15:0]        tx_byte;
  logic [1:0]         tx_take;
  logic [7:0]         rx_byte;
  logic [1:0]         rx_valid;
  logic [1:0]         grant;
  logic [1:0]         txn_done;
  logic [1:0]         cs_n;
  logic               eng_go;
  logic [7:0]         eng_tx;
  logic [7:0]         eng_rx;
  logic               eng_done;

  modport master (
    output req, len, tx_byte, eng_rx, eng_done,
    input  tx_take, rx_byte, rx_valid, grant, txn_done, cs_n, eng_go, eng_tx
  );

  modport slave (
    input  req, len, tx_byte, eng_rx, eng_done,
    output tx_take, rx_byte, rx_valid, grant, txn_done, cs_n, eng_go, eng_tx
  );
endinterface

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin picker (combinational).
//   req  : requests, one bit per requester
//   last : index of the requester served most recently
//   gnt  : one-hot pick, zero when nobody requests
// The requester that was not served last has priority.
module spi_rr_arb2
  import spi_txn_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (last) begin
      if (req[REQ_SD])       gnt[REQ_SD]  = 1'b1;
      else if (req[REQ_MP3]) gnt[REQ_MP3] = 1'b1;
    end else begin
      if (req[REQ_MP3])      gnt[REQ_MP3] = 1'b1;
      else if (req[REQ_SD])  gnt[REQ_SD]  = 1'b1;
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI byte engine between the SD reader and the MP3 decoder.
// Grants round-robin, owns both chip selects, and runs each multi-byte
// transaction as back-to-back engine operations framed by CS setup/hold gaps.
//   clk, rst  : clock, synchronous active-low reset
//   bus       : arbiter side of spi_txn_arbiter_if (requesters + byte engine)
//   fsm_state : current FSM state, for observation
module spi_txn_arbiter
  import spi_txn_arbiter_pkg::*;
#(
  parameter int LEN_W    = 9,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                clk,
  input  logic                rst,
  spi_txn_arbiter_if.slave    bus,
  output state_t              fsm_state
);

  localparam int CNT_W = 8;

  state_t           state;
  logic             last;
  logic             g;
  logic [LEN_W-1:0] remaining;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       pick;
  logic [LEN_W-1:0] pick_len;
  logic [7:0]       sel_tx;

  spi_rr_arb2 u_arb (
    .req  (bus.req),
    .last (last),
    .gnt  (pick)
  );

  assign pick_len  = pick[REQ_MP3] ? bus.len[2*LEN_W-1:LEN_W] : bus.len[LEN_W-1:0];
  assign sel_tx    = g ? bus.tx_byte[15:8] : bus.tx_byte[7:0];
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      last          <= 1'b1;
      g             <= 1'b0;
      remaining     <= '0;
      cnt           <= '0;
      bus.cs_n      <= 2'b11;
      bus.grant     <= 2'b00;
      bus.eng_go    <= 1'b0;
      bus.eng_tx    <= 8'h00;
      bus.tx_take   <= 2'b00;
      bus.rx_valid  <= 2'b00;
      bus.txn_done  <= 2'b00;
      bus.rx_byte   <= 8'h00;
    end else begin
      // Pulse outputs default low; states below raise them for one cycle.
      bus.eng_go   <= 1'b0;
      bus.tx_take  <= 2'b00;
      bus.rx_valid <= 2'b00;
      bus.txn_done <= 2'b00;

      case (state)
        S_IDLE: begin
          // A zero-length grant leaves grant high for the txn_done cycle;
          // drop it here before arbitrating again.
          if (|bus.grant) begin
            bus.grant <= 2'b00;
          end else if (|pick) begin
            g         <= pick[REQ_MP3];
            last      <= pick[REQ_MP3];
            bus.grant <= pick;
            if (pick_len == '0) begin
              bus.txn_done <= pick;
            end else begin
              remaining <= pick_len;
              bus.cs_n  <= ~pick;
              cnt       <= CNT_W'(CS_SETUP - 1);
              state     <= S_SETUP;
            end
          end
        end

        // eng_go is registered on entry to ISSUE so it is high while in ISSUE.
        S_SETUP: begin
          if (cnt == '0) begin
            state       <= S_ISSUE;
            bus.eng_go  <= 1'b1;
            bus.eng_tx  <= sel_tx;
            bus.tx_take <= bus.grant;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_ISSUE: state <= S_WAIT;

        S_WAIT: begin
          if (bus.eng_done) begin
            bus.rx_byte  <= bus.eng_rx;
            bus.rx_valid <= bus.grant;
            remaining    <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) begin
              cnt   <= CNT_W'(CS_HOLD - 1);
              state <= S_HOLD;
            end else begin
              state       <= S_ISSUE;
              bus.eng_go  <= 1'b1;
              bus.eng_tx  <= sel_tx;
              bus.tx_take <= bus.grant;
            end
          end
        end

        S_HOLD: begin
          if (cnt == '0) begin
            bus.cs_n     <= 2'b11;
            bus.txn_done <= bus.grant;
            state        <= S_RELEASE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        S_RELEASE: begin
          bus.grant <= 2'b00;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: requester and byte-engine models, directed
// transactions, and a scoreboard monitor that checks every DUT event.
module tb_spi_txn_arbiter;
  import spi_txn_arbiter_pkg::*;

  localparam int LEN_W    = 9;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int ENG_LAT  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_txn_arbiter_if #(.LEN_W(LEN_W)) bus ();
  state_t dbg_state;

  spi_txn_arbiter #(.LEN_W(LEN_W), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (dbg_state)
  );

  logic             req0_v = 1'b0, req1_v = 1'b0;
  logic [LEN_W-1:0] len0_v = '0, len1_v = '0;
  logic [7:0]       tx0_v = 8'h00, tx1_v = 8'h00;
  logic             eng_done_v = 1'b0;
  logic [7:0]       eng_rx_v = 8'h00;

  assign bus.req      = {req1_v, req0_v};
  assign bus.len      = {len1_v, len0_v};
  assign bus.tx_byte  = {tx1_v, tx0_v};
  assign bus.eng_done = eng_done_v;
  assign bus.eng_rx   = eng_rx_v;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_tx_q[$];
  logic [8:0] exp_rx_q[$];
  logic [0:0] exp_done_q[$];
  logic [0:0] exp_gnt_q[$];

  logic [7:0] tx_q0[$];
  logic [7:0] tx_q1[$];
  logic [7:0] rsp_q[$];
  int spur_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event (t=%0t)", name, $time);
  endtask

  // ---------------- requester model ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      if (bus.tx_take[0] && tx_q0.size() > 0) void'(tx_q0.pop_front());
      if (bus.tx_take[1] && tx_q1.size() > 0) void'(tx_q1.pop_front());
      tx0_v = (tx_q0.size() > 0) ? tx_q0[0] : 8'h00;
      tx1_v = (tx_q1.size() > 0) ? tx_q1[0] : 8'h00;
    end
  end

  // ---------------- byte engine model ----------------
  initial begin
    int spur_served = 0;
    int wait_cnt = 0;
    bit pend = 0;
    logic [7:0] cur = 8'h00;
    forever begin
      @(posedge clk); #1;
      eng_done_v = 1'b0;
      if (spur_served < spur_cnt) begin
        spur_served++;
        eng_done_v = 1'b1;
        eng_rx_v   = 8'hEE;
      end else if (pend && wait_cnt == 0) begin
        eng_done_v = 1'b1;
        eng_rx_v   = cur;
        pend       = 0;
      end else if (pend) begin
        wait_cnt--;
      end
      if (bus.eng_go) begin
        pend     = 1;
        wait_cnt = ENG_LAT - 1;
        cur      = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'h00;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    int cyc = 0, fall_cyc = 0, rise_cyc = 0, done_cyc = 0;
    bit have_rise = 0, first_go = 0;
    logic [1:0] prev_cs = 2'b11;
    logic [1:0] prev_gnt = 2'b00;
    forever begin
      @(negedge clk);
      cyc++;
      check("cs_not_both_low", 32'(bus.cs_n == 2'b00), 32'd0);
      if (bus.grant == 2'b00) check("cs_high_without_grant", 32'(bus.cs_n), 32'h3);

      if (prev_cs == 2'b11 && bus.cs_n != 2'b11) begin
        if (rst && have_rise) check("cs_gap_ge2", 32'((cyc - rise_cyc) >= 2), 32'd1);
        fall_cyc = cyc;
        first_go = 1;
      end
      if (prev_cs != 2'b11 && bus.cs_n == 2'b11) begin
        // eng_done is seen one phase before the edge that samples it
        if (rst) check("cs_hold", 32'(cyc - done_cyc), 32'(CS_HOLD + 1));
        rise_cyc  = cyc;
        have_rise = 1;
        first_go  = 0;
      end
      if (bus.eng_done) done_cyc = cyc;

      if (bus.eng_go) begin
        if (exp_tx_q.size() == 0) flag("eng_go");
        else check("eng_tx", 32'(bus.eng_tx), 32'(exp_tx_q.pop_front()));
        if (first_go) begin
          check("cs_setup", 32'(cyc - fall_cyc), 32'(CS_SETUP));
          first_go = 0;
        end
      end
      if (|bus.rx_valid) begin
        if (exp_rx_q.size() == 0) flag("rx_valid");
        else check("rx_idx_byte", 32'({bus.rx_valid[1], bus.rx_byte}), 32'(exp_rx_q.pop_front()));
      end
      if (|bus.txn_done) begin
        if (exp_done_q.size() == 0) flag("txn_done");
        else check("txn_done_idx", 32'(bus.txn_done[1]), 32'(exp_done_q.pop_front()));
      end
      if (prev_gnt == 2'b00 && bus.grant != 2'b00) begin
        if (exp_gnt_q.size() == 0) flag("grant");
        else check("grant_idx", 32'(bus.grant[1]), 32'(exp_gnt_q.pop_front()));
      end
      if (bus.grant == 2'b11) flag("grant_both");
      prev_cs  = bus.cs_n;
      prev_gnt = bus.grant;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_txn(input int r, input int n, input logic [31:0] tx, input logic [31:0] rx);
    logic [7:0] b;
    logic [7:0] rb;
    exp_gnt_q.push_back(r[0]);
    exp_done_q.push_back(r[0]);
    for (int i = 0; i < n; i++) begin
      b  = tx[8*i +: 8];
      rb = rx[8*i +: 8];
      if (r == 0) tx_q0.push_back(b); else tx_q1.push_back(b);
      exp_tx_q.push_back(b);
      rsp_q.push_back(rb);
      exp_rx_q.push_back({r[0], rb});
    end
  endtask

  task automatic run_req(input int r, input int ln, input int ntxn);
    int seen = 0;
    if (r == 0) begin len0_v = LEN_W'(ln); req0_v = 1'b1; end
    else        begin len1_v = LEN_W'(ln); req1_v = 1'b1; end
    for (int i = 0; i < 3000 && seen < ntxn; i++) begin
      @(posedge clk); #1;
      if (bus.txn_done[r]) seen++;
    end
    if (r == 0) req0_v = 1'b0; else req1_v = 1'b0;
    check($sformatf("txn_count_r%0d", r), 32'(seen), 32'(ntxn));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    int gos;
    int seen;
    // reset values
    idle_cycles(3);
    check("rst_cs_n",     32'(bus.cs_n), 32'h3);
    check("rst_grant",    32'(bus.grant), 32'h0);
    check("rst_eng_go",   32'(bus.eng_go), 32'h0);
    check("rst_eng_tx",   32'(bus.eng_tx), 32'h0);
    check("rst_tx_take",  32'(bus.tx_take), 32'h0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
    check("rst_txn_done", 32'(bus.txn_done), 32'h0);
    check("rst_rx_byte",  32'(bus.rx_byte), 32'h0);
    check("rst_state",    32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b1;
    idle_cycles(2);

    // single 3-byte transaction from SD
    push_txn(0, 3, 32'h00FF3CA5, 32'h00332211);
    run_req(0, 3, 1);
    idle_cycles(4);

    // both requesting out of reset: SD first, then MP3
    rst = 1'b0;
    idle_cycles(2);
    rst = 1'b1;
    push_txn(0, 2, 32'h00002010, 32'h00004030);
    push_txn(1, 1, 32'h00000050, 32'h00000060);
    fork
      run_req(0, 2, 1);
      run_req(1, 1, 1);
    join
    idle_cycles(4);

    // MP3 held for two 1-byte txns, SD requests once in between: 1,0,1
    push_txn(1, 1, 32'h00000081, 32'h00000091);
    push_txn(0, 1, 32'h00000002, 32'h00000012);
    push_txn(1, 1, 32'h00000083, 32'h00000093);
    fork
      run_req(1, 1, 2);
      begin
        idle_cycles(3);
        run_req(0, 1, 1);
      end
    join
    idle_cycles(4);

    // zero-length request: txn_done only, no chip select, no engine op
    exp_gnt_q.push_back(1'b0);
    exp_done_q.push_back(1'b0);
    len0_v = '0;
    req0_v = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      @(posedge clk); #1;
      if (bus.txn_done[0]) begin
        seen = 1;
        check("len0_cs_n", 32'(bus.cs_n), 32'h3);
        check("len0_grant", 32'(bus.grant), 32'h1);
      end
    end
    req0_v = 1'b0;
    check("len0_done_seen", 32'(seen), 32'd1);
    idle_cycles(4);

    // reset during WAIT of byte 2 of a 4-byte transaction
    exp_gnt_q.push_back(1'b0);
    tx_q0.push_back(8'h01); tx_q0.push_back(8'h02);
    tx_q0.push_back(8'h03); tx_q0.push_back(8'h04);
    exp_tx_q.push_back(8'h01); exp_tx_q.push_back(8'h02);
    rsp_q.push_back(8'hC1); rsp_q.push_back(8'hC2);
    exp_rx_q.push_back({1'b0, 8'hC1});
    len0_v = LEN_W'(4);
    req0_v = 1'b1;
    gos = 0;
    for (int i = 0; i < 200 && gos < 2; i++) begin
      @(posedge clk); #1;
      if (bus.eng_go) gos++;
    end
    check("rst_reach_byte2", 32'(gos), 32'd2);
    idle_cycles(1);
    check("rst_in_wait", 32'(dbg_state), 32'(ST_WAIT));
    rst    = 1'b0;
    req0_v = 1'b0;
    idle_cycles(1);
    check("midrst_cs_n",     32'(bus.cs_n), 32'h3);
    check("midrst_grant",    32'(bus.grant), 32'h0);
    check("midrst_txn_done", 32'(bus.txn_done), 32'h0);
    check("midrst_state",    32'(dbg_state), 32'(ST_IDLE));
    tx_q0.delete();
    rst = 1'b1;
    idle_cycles(10);
    push_txn(1, 2, 32'h00008877, 32'h0000AA99);
    run_req(1, 2, 1);
    idle_cycles(4);

    // SD drops req after grant, len changes, spurious eng_done in SETUP
    push_txn(0, 2, 32'h0000695A, 32'h00005544);
    len0_v = LEN_W'(2);
    req0_v = 1'b1;
    seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      @(posedge clk); #1;
      if (bus.grant[0]) seen = 1;
    end
    check("drop_grant_seen", 32'(seen), 32'd1);
    req0_v = 1'b0;
    len0_v = LEN_W'(5);
    spur_cnt++;
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      @(posedge clk); #1;
      if (bus.txn_done[0]) seen = 1;
    end
    check("drop_txn_done", 32'(seen), 32'd1);
    idle_cycles(20);

    check("exp_tx_drained",   32'(exp_tx_q.size()), 32'd0);
    check("exp_rx_drained",   32'(exp_rx_q.size()), 32'd0);
    check("exp_done_drained", 32'(exp_done_q.size()), 32'd0);
    check("exp_gnt_drained",  32'(exp_gnt_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
